// File: rtl/stp_block_sr_if.sv
// rtl/stp_block_sr_if.sv - word-in / block-out handshake bundle for stp_block_sr
interface stp_block_sr_if #(
  parameter int WORDS = 16,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WORDS + 1);

  logic                   clear;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORDS*WIDTH-1:0] parallel_out;
  logic [CW-1:0]          fill_count;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, parallel_out, fill_count
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, parallel_out, fill_count
  );
endinterface

// File: rtl/stp_block_sr.sv
// rtl/stp_block_sr.sv - serial-to-parallel block assembler with valid/ready on both sides
// Optional STP_BYTE_SWAP_EN: byte-reverse each accepted word before storage.
module stp_block_sr #(
  parameter int WORDS = 16,
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  stp_block_sr_if.slave  bus
);
  localparam int CW = $clog2(WORDS + 1);
  localparam int BW = WORDS * WIDTH;
  localparam logic [CW-1:0] FULL = CW'(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   fill_count;
  logic [BW-1:0]   fill_buf;
  logic [BW-1:0]   filled;
  logic [BW-1:0]   out_reg;
  logic            out_valid_r;
  logic [WIDTH-1:0] word;
  logic            in_ready_c, out_free, accept, last_accept, load_fill, load_hold;

`ifdef STP_BYTE_SWAP_EN
  if (WIDTH % 8 != 0) begin : g_width_chk
    $error("stp_block_sr: WIDTH must be a multiple of 8 with byte swap enabled");
  end

  always_comb begin
    word = '0;
    for (int b = 0; b < WIDTH / 8; b++)
      word[8*(WIDTH/8-1-b) +: 8] = bus.in_data[8*b +: 8];
  end
`else
  assign word = bus.in_data;
`endif

  // Word k of a block lands in slot k counted from the MSB end.
  always_comb begin
    filled = fill_buf;
    for (int i = 0; i < WORDS; i++)
      if (fill_count == CW'(i))
        filled[WIDTH*(WORDS-1-i) +: WIDTH] = word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (last_accept && !out_free) state_nx = HOLD;
      HOLD:    if (bus.clear || out_free)    state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  // clear wins over a same-cycle accept and over a pending HOLD transfer.
  always_comb begin
    in_ready_c  = (fill_count != FULL);
    out_free    = !out_valid_r || bus.out_ready;
    accept      = bus.in_valid && in_ready_c && !bus.clear;
    last_accept = accept && (fill_count == LAST);
    load_fill   = last_accept && out_free;
    load_hold   = (state == HOLD) && out_free && !bus.clear;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_count  <= '0;
      fill_buf    <= '0;
      out_reg     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (bus.clear || load_fill || load_hold) fill_count <= '0;
      else if (last_accept)                    fill_count <= FULL;
      else if (accept)                         fill_count <= fill_count + CW'(1);

      if (accept) fill_buf <= filled;

      if (load_fill)      out_reg <= filled;
      else if (load_hold) out_reg <= fill_buf;

      if (load_fill || load_hold) out_valid_r <= 1'b1;
      else if (bus.out_ready)     out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_r;
  assign bus.parallel_out = out_reg;
  assign bus.fill_count   = fill_count;
endmodule

// File: tb/tb_stp_block_sr.sv
// tb/tb_stp_block_sr.sv - scoreboard bench for stp_block_sr (STP_BYTE_SWAP_EN selects 4x64 swap build)
module tb_stp_block_sr;
`ifdef STP_BYTE_SWAP_EN
  localparam int WORDS = 4;
  localparam int WIDTH = 64;
`else
  localparam int WORDS = 16;
  localparam int WIDTH = 32;
`endif
  localparam int CW    = $clog2(WORDS + 1);
  localparam int NPART = (WORDS > 7) ? 7 : WORDS - 1;

  typedef logic [WIDTH-1:0]       word_t;
  typedef logic [WORDS*WIDTH-1:0] blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stp_block_sr_if #(.WORDS(WORDS), .WIDTH(WIDTH)) bus ();
  stp_block_sr #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int    compared   = 0;
  int    mismatched = 0;
  word_t acc_words[$];
  blk_t  exp_q[$];
  blk_t  held;
  int    m_fill = 0;
  bit    m_ov   = 1'b0;

  function automatic word_t swap_w(word_t d);
`ifdef STP_BYTE_SWAP_EN
    word_t r;
    for (int b = 0; b < WIDTH / 8; b++) r[8*(WIDTH/8-1-b) +: 8] = d[8*b +: 8];
    return r;
`else
    return d;
`endif
  endfunction

  function automatic blk_t make_blk(int base);
    blk_t b;
    for (int k = 0; k < WORDS; k++) b[WIDTH*(WORDS-1-k) +: WIDTH] = swap_w(word_t'(base + k));
    return b;
  endfunction

  task automatic model_reset();
    acc_words.delete();
    exp_q.delete();
    m_fill = 0;
    m_ov   = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the reference model over the edge, return at edge+1.
  task automatic step(input logic v, input word_t d, input logic rdy, input logic clr);
    bit   ov_next, out_free;
    blk_t b;
    bus.in_valid = v; bus.in_data = d; bus.out_ready = rdy; bus.clear = clr;
    @(posedge clk);
    out_free = !m_ov || rdy;
    ov_next  = m_ov && !rdy;
    if (clr) begin
      m_fill = 0;
      acc_words.delete();
    end else if (m_fill == WORDS) begin
      if (out_free) begin exp_q.push_back(held); ov_next = 1'b1; m_fill = 0; end
    end else if (v) begin
      acc_words.push_back(swap_w(d));
      if (acc_words.size() == WORDS) begin
        for (int k = 0; k < WORDS; k++) b[WIDTH*(WORDS-1-k) +: WIDTH] = acc_words[k];
        acc_words.delete();
        if (out_free) begin exp_q.push_back(b); ov_next = 1'b1; m_fill = 0; end
        else begin held = b; m_fill = WORDS; end
      end else begin
        m_fill++;
      end
    end
    m_ov = ov_next;
    #1;
  endtask

  always @(negedge clk) begin
    blk_t e;
    if (!rst) begin
      compared++;
      if (bus.fill_count !== CW'(m_fill)) begin
        mismatched++; $display("FAIL mon_fill_count got %0d want %0d", bus.fill_count, m_fill);
      end
      compared++;
      if (bus.in_ready !== (m_fill != WORDS)) begin
        mismatched++; $display("FAIL mon_in_ready got %b want %b", bus.in_ready, m_fill != WORDS);
      end
      compared++;
      if (bus.out_valid !== m_ov) begin
        mismatched++; $display("FAIL mon_out_valid got %b want %b", bus.out_valid, m_ov);
      end
      if (bus.out_valid && bus.out_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++; $display("FAIL sb_unexpected_block got %h want none", bus.parallel_out);
        end else begin
          e = exp_q.pop_front();
          if (bus.parallel_out !== e) begin
            mismatched++; $display("FAIL sb_block got %h want %h", bus.parallel_out, e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0; bus.clear = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    compared++; if (bus.parallel_out !== '0) begin mismatched++; $display("FAIL rst_parallel_out got %h want 0", bus.parallel_out); end
    compared++; if (bus.fill_count !== '0) begin mismatched++; $display("FAIL rst_fill_count got %0d want 0", bus.fill_count); end
    compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, word_t'(32'h80 + i), 1'b1, 1'b0);
    compared++; if (bus.fill_count !== CW'(5)) begin mismatched++; $display("FAIL mid_fill_count got %0d want 5", bus.fill_count); end
    rst = 1'b1;
    model_reset();
    #1;
    compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); end
    compared++; if (bus.parallel_out !== '0) begin mismatched++; $display("FAIL midrst_parallel_out got %h want 0", bus.parallel_out); end
    compared++; if (bus.fill_count !== '0) begin mismatched++; $display("FAIL midrst_fill_count got %0d want 0", bus.fill_count); end
    compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < WORDS; i++) step(1'b1, word_t'(32'h100 + i), 1'b1, 1'b0);
    compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL postrst_out_valid got %b want 1", bus.out_valid); end
    compared++; if (bus.parallel_out !== make_blk(32'h100)) begin mismatched++; $display("FAIL postrst_block got %h want %h", bus.parallel_out, make_blk(32'h100)); end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 2 * WORDS; i++) begin
      compared++;
      if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL stream_stall cycle %0d got %b want 1", i, bus.in_ready); end
      step(1'b1, (i < WORDS) ? word_t'(i) : word_t'(32'h40 + i - WORDS), 1'b1, 1'b0);
      if (i == WORDS - 1) begin
        compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL stream_latency got %b want 1", bus.out_valid); end
        compared++;
        if (bus.parallel_out[WORDS*WIDTH-1 -: WIDTH] !== swap_w(word_t'(0))) begin
          mismatched++; $display("FAIL stream_slot0 got %h want %h", bus.parallel_out[WORDS*WIDTH-1 -: WIDTH], swap_w(word_t'(0)));
        end
        compared++;
        if (bus.parallel_out[WIDTH-1:0] !== swap_w(word_t'(WORDS - 1))) begin
          mismatched++; $display("FAIL stream_slot_last got %h want %h", bus.parallel_out[WIDTH-1:0], swap_w(word_t'(WORDS - 1)));
        end
      end
    end
    step(1'b0, '0, 1'b1, 1'b0);
    compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL stream_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < WORDS; i++) step(1'b1, word_t'(32'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < WORDS; i++) step(1'b1, word_t'(32'h20 + i), 1'b0, 1'b0);
    compared++; if (bus.fill_count !== CW'(WORDS)) begin mismatched++; $display("FAIL bp_fill_count got %0d want %0d", bus.fill_count, WORDS); end
    compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
    step(1'b1, word_t'(32'hEE), 1'b0, 1'b0);
    compared++; if (bus.parallel_out !== make_blk(32'h10)) begin mismatched++; $display("FAIL bp_held_a got %h want %h", bus.parallel_out, make_blk(32'h10)); end
    step(1'b0, '0, 1'b1, 1'b0);
    compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_b_valid got %b want 1", bus.out_valid); end
    compared++; if (bus.parallel_out !== make_blk(32'h20)) begin mismatched++; $display("FAIL bp_b_block got %h want %h", bus.parallel_out, make_blk(32'h20)); end
    compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_ready_back got %b want 1", bus.in_ready); end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < WORDS; i++) step(1'b1, word_t'(32'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < WORDS - 1; i++) step(1'b1, word_t'(32'h70 + i), 1'b0, 1'b0);
    compared++; if (bus.parallel_out !== make_blk(32'h30)) begin mismatched++; $display("FAIL simul_a got %h want %h", bus.parallel_out, make_blk(32'h30)); end
    step(1'b1, word_t'(32'h70 + WORDS - 1), 1'b1, 1'b0);
    compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL simul_valid got %b want 1", bus.out_valid); end
    compared++; if (bus.parallel_out !== make_blk(32'h70)) begin mismatched++; $display("FAIL simul_b got %h want %h", bus.parallel_out, make_blk(32'h70)); end
    compared++; if (bus.fill_count !== '0) begin mismatched++; $display("FAIL simul_fill got %0d want 0", bus.fill_count); end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < WORDS; i++) step(1'b1, word_t'(32'h50 + i), 1'b0, 1'b0);
    for (int i = 0; i < NPART; i++) step(1'b1, word_t'(32'h90 + i), 1'b0, 1'b0);
    compared++; if (bus.fill_count !== CW'(NPART)) begin mismatched++; $display("FAIL clr_partial got %0d want %0d", bus.fill_count, NPART); end
    step(1'b1, word_t'(32'hDEADBEEF), 1'b0, 1'b1);
    compared++; if (bus.fill_count !== '0) begin mismatched++; $display("FAIL clr_fill got %0d want 0", bus.fill_count); end
    compared++; if (bus.parallel_out !== make_blk(32'h50)) begin mismatched++; $display("FAIL clr_out_kept got %h want %h", bus.parallel_out, make_blk(32'h50)); end
    for (int i = 0; i < WORDS; i++) step(1'b1, word_t'(32'h60 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    compared++; if (bus.parallel_out !== make_blk(32'h60)) begin mismatched++; $display("FAIL clr_next_block got %h want %h", bus.parallel_out, make_blk(32'h60)); end
    for (int i = 0; i < WORDS; i++) step(1'b1, word_t'(32'hA0 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    compared++; if (bus.fill_count !== '0) begin mismatched++; $display("FAIL clr_hold_fill got %0d want 0", bus.fill_count); end
    compared++; if (bus.parallel_out !== make_blk(32'h60)) begin mismatched++; $display("FAIL clr_hold_out got %h want %h", bus.parallel_out, make_blk(32'h60)); end
    step(1'b0, '0, 1'b1, 1'b0);
    compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL clr_hold_dropped got %b want 0", bus.out_valid); end
  endtask

`ifdef STP_BYTE_SWAP_EN
  task automatic test_byte_swap();
    word_t w0;
    logic [63:0] want;
    w0   = 64'h0102030405060708;
    want = 64'h0807060504030201;
    step(1'b1, w0, 1'b1, 1'b0);
    for (int i = 1; i < WORDS; i++) begin
      compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL swap_early_valid got %b want 0", bus.out_valid); end
      step(1'b1, word_t'(i), 1'b1, 1'b0);
    end
    compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL swap_valid got %b want 1", bus.out_valid); end
    compared++; if (bus.parallel_out[WORDS*WIDTH-1 -: 64] !== want) begin mismatched++; $display("FAIL swap_slot0 got %h want %h", bus.parallel_out[WORDS*WIDTH-1 -: 64], want); end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_clear();
`ifdef STP_BYTE_SWAP_EN
    test_byte_swap();
`endif
    step(1'b0, '0, 1'b1, 1'b0);
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL sb_leftover got %0d blocks want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/stp_block_sr.md
# stp_block_sr

Parametrised serial-to-parallel block assembler with valid/ready flow control on both sides. It collects WORDS words of WIDTH bits into one WORDS*WIDTH-bit block, by default 16 x 32 = 512-bit SHA-256 message blocks, and presents each block on a registered output that is held under backpressure. It sits between the word-serial message/nonce feeder and the SHA core input. It is the flow-controlled, width/depth-generic successor of the fixed 16-word shifter.

## Interface
- WORDS, 16, words per block; 2 or more.
- WIDTH, 32, bits per word.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous discard of the partially filled block.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  serial word.
- out_valid  out  1  parallel_out holds a complete block.
- out_ready  in  1  consumer takes the block this cycle.
- parallel_out  out  WORDS*WIDTH  assembled block.
- fill_count  out  $clog2(WORDS+1)  words held in the fill buffer, 0..WORDS.

## Operation
- **Input accept:** a word is accepted when in_valid && in_ready.
- **Word placement:** the k-th accepted word of a block (k = 0..WORDS-1) is stored at bits [WIDTH*(WORDS-k)-1 : WIDTH*(WORDS-k-1)]. Word 0 lands in the MSBs, matching big-endian SHA W0 ordering.
- **Fill buffer:** holds the block being assembled plus fill_count.
- **Output register:** holds parallel_out and out_valid.
- **out_free:** true when !out_valid || out_ready.
- **Block completion, output free:** when the accepted word is word WORDS-1 and out_free is true, the full block, including that word, loads into the output register on the same edge. out_valid goes to 1 and fill_count goes to 0.
- **Block completion, output busy:** if out_free is false, the fill buffer keeps the block and fill_count = WORDS. This is the HOLD state.
- **HOLD:** in_ready = 0. On the first edge with out_free true, the block transfers to the output register and fill_count returns to 0.
- **in_ready:** in_ready = (fill_count != WORDS). It is purely a function of state, with no combinational path from out_ready.
- **Output drain:** out_valid clears on out_ready unless a new block loads on the same edge, in which case it stays 1.
- **Output stability:** parallel_out is stable while out_valid && !out_ready.
- **clear:** zeroes fill_count, and in HOLD it discards the held block. It does not touch the output register. clear has priority over a same-cycle accept, so the word is dropped.
- **States:** FILL (fill_count < WORDS) and HOLD (fill_count == WORDS). Transitions:
  - FILL->FILL on an accept that is not the last word.
  - FILL->FILL on a last-word accept with out_free (block goes directly to output).
  - FILL->HOLD on a last-word accept without out_free.
  - HOLD->FILL on out_free or clear.

## Timing
- **Reset values:** parallel_out = 0, out_valid = 0, fill_count = 0, in_ready = 1. The fill buffer contents are also zeroed.
- **Latency:** from the edge accepting the last word to out_valid = 1 is 0 cycles, i.e. the same edge, when out_free is true.
- **Throughput:** with out_ready tied high, one word is accepted per cycle and one block is emitted every WORDS cycles with no bubbles.
- **Simultaneous events:** a consumer handshake and a last-word accept on the same edge replace the output block seamlessly, with out_valid staying 1.
- **Reset mid-block:** asserting rst mid-block drops all partial and pending data immediately.
- **Counter width:** fill_count uses $clog2(WORDS+1) bits and never exceeds WORDS.

## Configuration
- **Macro:** STP_BYTE_SWAP_EN.
- **When defined:** each accepted word is byte-reversed before storage (in_data[7:0] goes to the MSB byte of the slot). WIDTH must then be a multiple of 8, checked by an elaboration-time assertion.
- **When undefined:** words are stored unmodified. Use this for feeders that already supply big-endian words.

## Test plan
- **Reset:** assert rst mid-block after 5 words -> immediately out_valid = 0, parallel_out = 0, fill_count = 0, in_ready = 1. The next 16 words form a clean block.
- **Streaming:** WORDS = 16, WIDTH = 32, out_ready = 1, feed 0x00000000..0x0000000F on consecutive cycles -> out_valid pulses after the 16th word with bits [511:480] = 0x0, [31:0] = 0xF. The next block is accepted with no stall.
- **Backpressure:** hold out_ready = 0, then stream two blocks (A = 0x10.., B = 0x20..) -> block A is held on parallel_out, B fills and fill_count = 16, in_ready = 0. Raising out_ready for one cycle -> A is taken, B appears on the next edge, in_ready = 1.
- **Simultaneous:** the last word of block B is accepted on the same edge as out_ready for A -> out_valid stays 1 and parallel_out switches to B with no gap.
- **clear:** after 7 words, assert clear with in_valid = 1 and in_data = 0xDEADBEEF -> fill_count = 0, the word is dropped, and an existing out_valid block is unchanged.
- **Byte swap and resize:** STP_BYTE_SWAP_EN defined, WORDS = 4, WIDTH = 64, words 0x0102030405060708.. -> slot 0 = 0x0807060504030201 and out_valid after the 4th word.
